// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button conditioning path.
package key_pkg;

  typedef enum logic [1:0] {K_UP, K_ARM_DOWN, K_DOWN, K_ARM_UP} key_state_t;

  localparam int unsigned CLK_HZ = 50_000_000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button channel: synchroniser, debounce FSM, auto-repeat timer and
// registered level/strobe outputs.
module key_channel
  import key_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_PERIOD   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam bit REP_EN  = (REPEAT_DELAY > 0);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PER_LAST   = REP_W'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   key_s;
  key_state_t             state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [REP_W-1:0]       rep_cnt, rep_cnt_next;
  logic                   rep_first, rep_first_next;
  logic                   rep_due;
  logic                   pressed_next, press_next, release_next, repeat_next;

  // KEY is active-low, so a low synchronised level means the button is held.
  assign key_s = ~sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync          <= '1;
      state         <= K_UP;
      cnt           <= '0;
      rep_cnt       <= '0;
      rep_first     <= 1'b1;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      sync          <= {sync[SYNC_STAGES-2:0], key};
      state         <= state_next;
      cnt           <= cnt_next;
      rep_cnt       <= rep_cnt_next;
      rep_first     <= rep_first_next;
      pressed       <= pressed_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      repeat_pulse  <= repeat_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    rep_cnt_next   = rep_cnt;
    rep_first_next = rep_first;
    pressed_next   = pressed;
    press_next     = 1'b0;
    release_next   = 1'b0;
    repeat_next    = 1'b0;
    rep_due        = REP_EN && (rep_first ? (rep_cnt == DELAY_LAST) : (rep_cnt == PER_LAST));

    // The first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; the
    // counter reloads on each hit, so it never exceeds its reload value.
    if (REP_EN && (state == K_DOWN || state == K_ARM_UP)) begin
      if (rep_due) begin
        repeat_next    = 1'b1;
        rep_cnt_next   = '0;
        rep_first_next = 1'b0;
      end else begin
        rep_cnt_next = rep_cnt + 1'b1;
      end
    end

    case (state)
      K_UP: begin
        if (key_s) begin
          state_next = K_ARM_DOWN;
          cnt_next   = '0;
        end
      end
      K_ARM_DOWN: begin
        if (!key_s) begin
          state_next = K_UP;
        end else if (cnt == CNT_LAST) begin
          state_next     = K_DOWN;
          press_next     = 1'b1;
          pressed_next   = 1'b1;
          rep_cnt_next   = '0;
          rep_first_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      K_DOWN: begin
        if (!key_s) begin
          state_next = K_ARM_UP;
          cnt_next   = '0;
        end
      end
      K_ARM_UP: begin
        if (key_s) begin
          state_next = K_DOWN;
        end else if (cnt == CNT_LAST) begin
          // An accepted release suppresses a repeat due in the same cycle.
          state_next   = K_UP;
          release_next = 1'b1;
          pressed_next = 1'b0;
          repeat_next  = 1'b0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = K_UP;
    endcase
  end

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw active-low buttons into debounced levels and strobes,
// one fully independent channel per key.
module key_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = int'(ms_to_cycles(20)),
  parameter int REPEAT_DELAY    = int'(ms_to_cycles(500)),
  parameter int REPEAT_PERIOD   = int'(ms_to_cycles(100))
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk          (CLOCK_50),
      .rst          (reset),
      .key          (KEY[i]),
      .pressed      (pressed[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed test-plan scenarios plus random key
// activity, checked by a scoreboard fed from a behavioural debounce model.
module tb_key_conditioner;

  localparam int NK     = 4;
  localparam int DEB    = 4;
  localparam int RDELAY = 10;
  localparam int RPER   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] KEY;
  logic [NK-1:0] pressed, press_pulse, release_pulse, repeat_pulse;

  int checks   = 0;
  int failures = 0;

  // Expected strobe events: {pressed, press, release, repeat}.
  logic [4*NK-1:0] exp_q[$];

  key_conditioner #(
    .NUM_KEYS(NK), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPER)
  ) dut (
    .CLOCK_50(clk), .reset(rst), .KEY(KEY), .pressed(pressed),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A change is accepted after DEB+1 consecutive samples of the new level,
  // seen through a two-cycle synchroniser delay.
  logic [NK-1:0] m_kq0, m_kq1, m_acc;
  int m_run[NK];
  int m_since[NK];

  task automatic model_reset();
    m_kq0 = '1; m_kq1 = '1; m_acc = '0;
    for (int i = 0; i < NK; i++) begin
      m_run[i] = 0; m_since[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [NK-1:0] pr, rl, rp;
    logic s;
    pr = '0; rl = '0; rp = '0;
    for (int i = 0; i < NK; i++) begin
      s = ~m_kq1[i];
      if (m_acc[i]) m_since[i]++;
      if (s != m_acc[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == DEB + 1) begin
        m_acc[i] = s;
        m_run[i] = 0;
        if (s) begin pr[i] = 1'b1; m_since[i] = 0; end
        else rl[i] = 1'b1;
      end
      if (m_acc[i] && !pr[i] && RDELAY > 0 && m_since[i] >= RDELAY &&
          (m_since[i] - RDELAY) % RPER == 0)
        rp[i] = 1'b1;
    end
    m_kq1 = m_kq0;
    m_kq0 = KEY;
    if (|{pr, rl, rp}) exp_q.push_back({m_acc, pr, rl, rp});
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [4*NK-1:0] got, e;
    if (!rst) begin
      got = {pressed, press_pulse, release_pulse, repeat_pulse};
      if (|{press_pulse, release_pulse, repeat_pulse}) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_strobe got=%h exp=none t=%0t", got, $time);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL sb_strobe got=%h exp=%h t=%0t", got, e, $time);
          end
        end
      end else if (exp_q.size() != 0) begin
        checks++;
        failures++;
        e = exp_q.pop_front();
        $display("FAIL sb_missed_strobe got=%h exp=%h t=%0t", got, e, $time);
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  function automatic logic [NK-1:0] sel(input int kind);
    case (kind)
      0: return press_pulse;
      1: return release_pulse;
      2: return repeat_pulse;
      3: return pressed;
      default: return press_pulse | release_pulse | ~pressed;
    endcase
  endfunction

  task automatic drive(input logic [NK-1:0] k);
    @(negedge clk);
    KEY = k;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // First edge on which the selected strobe vector is non-zero must be exp_cyc
  // and carry exactly mask.
  task automatic expect_strobe(input string name, input int kind,
                               input logic [NK-1:0] mask, input int exp_cyc);
    logic [NK-1:0] v;
    bit seen;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk); #1;
      v = sel(kind);
      if (v != '0) begin
        seen = 1'b1;
        checks++;
        if (v !== mask || c != exp_cyc) begin
          failures++;
          $display("FAIL %s got=%b@%0d exp=%b@%0d", name, v, c, mask, exp_cyc);
        end
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=none exp=%b@%0d", name, mask, exp_cyc);
    end
  endtask

  task automatic watch(input int n, input int kind, input logic [NK-1:0] mask,
                       output int hits);
    hits = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if ((sel(kind) & mask) != '0) hits++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int h1, h2, press_at;
    int rep_q[$];
    int exp_rep[4];
    logic [NK-1:0] k;

    exp_rep = '{17, 20, 23, 26};
    rst = 1'b1;
    KEY = '1;
    repeat (3) @(negedge clk);
    check("reset_pressed", int'(pressed), 0);
    check("reset_press", int'(press_pulse), 0);
    check("reset_release", int'(release_pulse), 0);
    check("reset_repeat", int'(repeat_pulse), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Clean press on KEY[3].
    drive(4'b0111);
    expect_strobe("clean_press", 0, 4'b1000, 7);
    check("clean_pressed_level", int'(pressed), 8);

    // Short release glitch while held must be ignored.
    drive(4'b1111);
    watch(2, 4, 4'b1000, h1);
    drive(4'b0111);
    watch(10, 4, 4'b1000, h2);
    check("glitch_immunity_hits", h1 + h2, 0);

    // Real release.
    drive(4'b1111);
    expect_strobe("release_latency", 1, 4'b1000, 7);
    check("release_pressed_level", int'(pressed), 0);
    repeat (5) @(negedge clk);

    // Bounce on KEY[2]: low 3, high 2, then held low.
    drive(4'b1011);
    watch(3, 0, 4'b0100, h1);
    drive(4'b1111);
    watch(2, 0, 4'b0100, h2);
    check("bounce_no_early_press", h1 + h2, 0);
    drive(4'b1011);
    expect_strobe("bounce_press", 0, 4'b0100, 7);
    drive(4'b1111);
    expect_strobe("bounce_release", 1, 4'b0100, 7);
    repeat (5) @(negedge clk);

    // Auto-repeat on KEY[1].
    drive(4'b1101);
    press_at = 0;
    for (int c = 1; c <= 27; c++) begin
      @(posedge clk); #1;
      if (press_pulse[1]) press_at = c;
      if (repeat_pulse[1]) rep_q.push_back(c);
    end
    check("repeat_press_cycle", press_at, 7);
    check("repeat_count", rep_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("repeat_cycle_%0d", i), (i < rep_q.size()) ? rep_q[i] : -1, exp_rep[i]);
    drive(4'b1111);
    expect_strobe("repeat_release", 1, 4'b0010, 7);
    watch(15, 2, 4'b0010, h1);
    check("repeat_stops_after_release", h1, 0);

    // Simultaneous press on KEY[0] and KEY[3].
    drive(4'b0110);
    expect_strobe("simultaneous_press", 0, 4'b1001, 7);
    repeat (4) @(negedge clk);

    // Reset mid-hold: outputs clear asynchronously, fresh press, no release.
    #2 rst = 1'b1;
    #1 check("midreset_pressed", int'(pressed), 0);
    check("midreset_strobes", int'(press_pulse | release_pulse | repeat_pulse), 0);
    @(negedge clk);
    rst = 1'b0;
    expect_strobe("post_reset_press", 0, 4'b1001, 7);
    watch(12, 1, 4'b1111, h1);
    check("post_reset_no_release", h1, 0);
    drive(4'b1111);
    repeat (15) @(negedge clk);

    // Random key activity, checked entirely by the scoreboard.
    k = '1;
    repeat (2000) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 9) == 0) k[i] = ~k[i];
      drive(k);
    end
    drive('1);
    repeat (30) @(negedge clk);
    check("sb_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
